// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data width, parity and stop bits
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int BAUD_DIV   = 5208,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          rs232_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int IW = $clog2(DATA_W);
   localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       baud_q, baud_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic [AW:0]         count_q, count_d;
   logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic                push, pop, empty, bit_end;

   assign tx_ready   = count_q != (AW+1)'(FIFO_DEPTH);
   assign push       = tx_valid & tx_ready;
   assign empty      = count_q == '0;
   assign bit_end    = baud_q == '0;
   assign rs232_tx   = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   // FIFO bookkeeping; power-of-two depth lets the pointers wrap naturally
   always_comb begin
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      wr_d    = wr_q + AW'(push);
      rd_d    = rd_q + AW'(pop);
   end

   // Frame sequencer; a frame start (pop) is shared by IDLE and the final stop cycle
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? BAUD_MAX : baud_q - 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            pop    = !empty;
         end
         S_START: if (bit_end) begin
            state_d = S_DATA;
            tx_d    = shift_q[0];
         end
         S_DATA: if (bit_end) begin
            par_d   = par_q ^ shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[1];
            if (idx_q == IW'(DATA_W - 1)) begin
               idx_d   = '0;
               state_d = (PARITY != 0) ? S_PAR : S_STOP;
               tx_d    = (PARITY != 0) ? (par_q ^ shift_q[0] ^ 1'(PARITY == 1)) : 1'b1;
            end
         end
         S_PAR: if (bit_end) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
         end
         S_STOP: if (bit_end) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(STOP_BITS - 1)) begin
               pop     = !empty;
               state_d = S_IDLE;
               baud_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         state_d = S_START;
         shift_d = mem[rd_q];
         tx_d    = 1'b0;
         par_d   = 1'b0;
         idx_d   = '0;
         baud_d  = BAUD_MAX;
      end
      busy_d = state_d != S_IDLE;
   end

   // FIFO storage; contents need no reset since the count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= tx_data;
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: frame-level checks of uart_tx_fifo in several frame formats against a bit-position model
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data [4];
   logic       valid [4];
   logic       ready [4];
   logic       line [4];
   logic       busy [4];
   logic [2:0] cnt [4];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] q [$];

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
      .rs232_tx(line[0]), .busy(busy[0]), .fifo_count(cnt[0]));
   uart_tx_fifo #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
      .rs232_tx(line[1]), .busy(busy[1]), .fifo_count(cnt[1]));
   uart_tx_fifo #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .reset(reset), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
      .rs232_tx(line[2]), .busy(busy[2]), .fifo_count(cnt[2]));
   uart_tx_fifo #(.DATA_W(7), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(3), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .reset(reset), .tx_data(data[3][6:0]), .tx_valid(valid[3]), .tx_ready(ready[3]),
      .rs232_tx(line[3]), .busy(busy[3]), .fifo_count(cnt[3]));

   function automatic int bd(int k);  return k == 3 ? 3 : 4; endfunction
   function automatic int dw(int k);  return k == 3 ? 7 : 8; endfunction
   function automatic int par(int k); return k == 1 ? 2 : (k == 2 ? 1 : 0); endfunction
   function automatic int sb(int k);  return k == 3 ? 2 : 1; endfunction
   function automatic int flen(int k);
      return bd(k) * (1 + dw(k) + (par(k) != 0 ? 1 : 0) + sb(k));
   endfunction
   function automatic logic [7:0] mask(int k); return 8'((1 << dw(k)) - 1); endfunction

   // Expected line level at cycle i of a frame carrying word w
   function automatic logic exp_bit(int k, logic [7:0] w, int i);
      int   b;
      logic p;
      b = i / bd(k);
      p = ^(w & mask(k));
      if (b == 0) return 1'b0;
      if (b <= dw(k)) return w[b-1];
      if (par(k) != 0 && b == dw(k) + 1) return par(k) == 2 ? p : ~p;
      return 1'b1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame(int k, logic [7:0] w);
      for (int i = 0; i < flen(k); i++) begin
         checks++;
         if (line[k] !== exp_bit(k, w, i)) begin
            errors++;
            $display("FAIL frame_bit u%0d word %h cycle %0d: got %b want %b", k, w, i, line[k], exp_bit(k, w, i));
         end
         checks++;
         if (busy[k] !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame u%0d word %h cycle %0d: got %b want 1", k, w, i, busy[k]);
         end
         tick;
      end
   endtask

   task automatic check_idle(int k, string nm);
      checks++;
      if (line[k] !== 1'b1 || busy[k] !== 1'b0 || cnt[k] !== 3'd0) begin
         errors++;
         $display("FAIL %s u%0d: got line=%b busy=%b count=%0d want line=1 busy=0 count=0", nm, k, line[k], busy[k], cnt[k]);
      end
   endtask

   task automatic wait_start(int k);
      int n = 0;
      while (line[k] !== 1'b0 && n < 200) begin
         tick;
         n++;
      end
      checks++;
      if (line[k] !== 1'b0) begin
         errors++;
         $display("FAIL start_timeout u%0d: got line=%b want 0 within 200 cycles", k, line[k]);
      end
   endtask

   task automatic test_single(int k, logic [7:0] w);
      data[k]  = w;
      valid[k] = 1'b1;
      tick;
      valid[k] = 1'b0;
      checks++;
      if (cnt[k] !== 3'd1 || line[k] !== 1'b1 || busy[k] !== 1'b0) begin
         errors++;
         $display("FAIL accept_edge u%0d: got count=%0d line=%b busy=%b want 1,1,0", k, cnt[k], line[k], busy[k]);
      end
      tick;
      checks++;
      if (cnt[k] !== 3'd0) begin
         errors++;
         $display("FAIL pop_edge u%0d: got count=%0d want 0", k, cnt[k]);
      end
      check_frame(k, w);
      check_idle(k, "after_frame");
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (line[k] !== 1'b1 || busy[k] !== 1'b0 || cnt[k] !== 3'd0 || ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL reset_state u%0d: got line=%b busy=%b count=%0d ready=%b want 1,0,0,1", k, line[k], busy[k], cnt[k], ready[k]);
         end
      end
      tick;
      tick;
      reset = 1'b0;
      tick;
      for (int k = 0; k < 4; k++) check_idle(k, "post_reset_idle");
   endtask

   task automatic test_8n1;
      test_single(0, 8'hA5);
   endtask

   task automatic test_parity;
      test_single(1, 8'h07);
      test_single(2, 8'h07);
      test_single(1, 8'h00);
      test_single(2, 8'h00);
   endtask

   task automatic test_stop2;
      test_single(3, 8'h55);
   endtask

   task automatic test_random;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 4; k++) test_single(k, 8'($urandom) & mask(k));
   endtask

   task automatic test_fifo_full;
      q.delete();
      fork
         begin
            int n = 0;
            int cyc = 0;
            valid[0] = 1'b1;
            while (n < 6 && cyc < 1000) begin
               if (ready[0]) begin
                  data[0] = 8'h11 + 8'(n);
                  q.push_back(data[0]);
                  n++;
               end else data[0] = 8'($urandom);
               tick;
               cyc++;
               if (cyc == 1 || cyc == 2) begin
                  checks++;
                  if (cnt[0] !== 3'd1) begin
                     errors++;
                     $display("FAIL full_count_e%0d: got %0d want 1", cyc - 1, cnt[0]);
                  end
               end
               if (cyc == 5) begin
                  checks++;
                  if (cnt[0] !== 3'd4 || ready[0] !== 1'b0) begin
                     errors++;
                     $display("FAIL full_ready: got count=%0d ready=%b want 4,0", cnt[0], ready[0]);
                  end
               end
            end
            valid[0] = 1'b0;
         end
         begin
            wait_start(0);
            for (int j = 0; j < 6; j++) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL full_order frame %0d: got no queued word want one", j);
               end else check_frame(0, q.pop_front());
            end
            check_idle(0, "full_drained");
         end
      join
   endtask

   task automatic test_simul;
      q.delete();
      fork
         begin
            valid[0] = 1'b1;
            data[0] = 8'($urandom);
            q.push_back(data[0]);
            tick;
            data[0] = 8'($urandom);
            q.push_back(data[0]);
            tick;
            valid[0] = 1'b0;
            checks++;
            if (cnt[0] !== 3'd1) begin
               errors++;
               $display("FAIL push_pop_first: got count=%0d want 1", cnt[0]);
            end
            repeat (39) tick;
            valid[0] = 1'b1;
            data[0] = 8'($urandom);
            q.push_back(data[0]);
            tick;
            valid[0] = 1'b0;
            checks++;
            if (cnt[0] !== 3'd1) begin
               errors++;
               $display("FAIL push_pop_last_stop: got count=%0d want 1", cnt[0]);
            end
         end
         begin
            wait_start(0);
            repeat (3) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL simul_order: got no queued word want one");
               end else check_frame(0, q.pop_front());
            end
            check_idle(0, "simul_drained");
         end
      join
   endtask

   task automatic test_reset_mid;
      logic [7:0] w0;
      w0 = 8'($urandom);
      valid[0] = 1'b1;
      data[0] = w0;
      tick;
      data[0] = 8'($urandom);
      tick;
      data[0] = 8'($urandom);
      tick;
      valid[0] = 1'b0;
      checks++;
      if (cnt[0] !== 3'd2) begin
         errors++;
         $display("FAIL mid_queued: got count=%0d want 2", cnt[0]);
      end
      repeat (16) tick;
      checks++;
      if (line[0] !== w0[3]) begin
         errors++;
         $display("FAIL mid_bit3: got %b want %b", line[0], w0[3]);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (line[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0 || ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_async_reset: got line=%b busy=%b count=%0d ready=%b want 1,0,0,1", line[0], busy[0], cnt[0], ready[0]);
      end
      tick;
      tick;
      reset = 1'b0;
      tick;
      check_idle(0, "mid_post_release");
      tick;
      check_idle(0, "mid_no_leftover");
      test_single(0, 8'h3C);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         data[k]  = 8'h00;
         valid[k] = 1'b0;
      end
      test_reset;
      test_8n1;
      test_parity;
      test_stop2;
      test_random;
      test_fifo_full;
      test_simul;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter for the scoreboard serial link. It takes words from a valid/ready source, buffers them in an internal FIFO and serialises them LSB-first onto `rs232_tx`. The frame format is configurable: data width, parity mode and stop-bit count. The baud tick is generated internally from a clock divisor. It replaces the fixed 8N1, externally-ticked, single-byte transmitter and sits between the score/command formatter and the board RS232 pin.

## Interface
- `DATA_W`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `BAUD_DIV`, 5208: clk cycles per bit, >= 2.
- `FIFO_DEPTH`, 4: entries, power of two, >= 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `tx_data`  in  DATA_W  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO not full; a word is accepted on a rising edge with `tx_valid & tx_ready`.
- `rs232_tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is on the line (state != IDLE), registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words buffered, registered.

## Operation
- Reset values: `rs232_tx`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1, FSM in IDLE, baud counter 0.
- FIFO:
  - Circular buffer with read/write pointers; `tx_ready` = (`fifo_count` != FIFO_DEPTH), combinational from the count register.
  - Push and pop in the same cycle leave the count unchanged.
  - A push is never accepted while full. A pop never occurs while empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high. If the FIFO is non-empty, pop the head into the shift register, drive `rs232_tx`=0, set the parity accumulator to 0 and the bit index to 0, and go to START.
  - START: hold 0 for BAUD_DIV cycles, then DATA.
  - DATA: drive shift[0]; after each BAUD_DIV-cycle bit, shift right and increment the index. After DATA_W bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY: drive XOR of the data bits for even parity, or its inverse for odd, for BAUD_DIV cycles. Then STOP.
  - STOP: drive 1 for STOP_BITS*BAUD_DIV cycles.
  - At the last STOP cycle: if the FIFO is non-empty, pop and enter START directly with no idle gap; otherwise go to IDLE.
- Baud counter:
  - Loads BAUD_DIV-1 at each bit start and decrements each cycle. The bit ends when it reaches 0.
  - Width $clog2(BAUD_DIV). It never wraps mid-bit.
- Frame length = BAUD_DIV*(1 + DATA_W + (PARITY!=0) + STOP_BITS) cycles exactly.
- Words are transmitted in acceptance order. No word is dropped or duplicated.
- `tx_data` and `tx_valid` changes while `tx_ready`=0 have no effect.

## Timing
- Acceptance edge E0: `fifo_count` updates at E0.
- If IDLE with an empty FIFO before E0: the pop occurs at E1, and `rs232_tx` falls and `busy` rises at E1. Latency is 1 clock from acceptance to the start bit.
- Each line level is held an exact multiple of BAUD_DIV cycles, measured edge to edge on the registered output.
- `busy` falls at the same edge `rs232_tx` enters IDLE high after the last stop bit. It stays 1 across back-to-back frames.
- Reset asserted mid-frame: `rs232_tx`=1 and `busy`=0 immediately (asynchronous). The FIFO is emptied and the partial frame is abandoned.
- After reset release, the first edge is a normal IDLE cycle.

## Test plan
- 8N1, BAUD_DIV=4: push 0xA5 -> line low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. `busy` high for exactly 40 cycles.
- Parity with DATA_W=8, BAUD_DIV=4:
  - PARITY=2, push 0x07 -> parity bit 1.
  - PARITY=1, push 0x07 -> parity bit 0.
  - PARITY=2, push 0x00 -> parity bit 0.
  - Frame is 44 cycles in each case.
- FIFO full, DEPTH=4, BAUD_DIV=4: hold `tx_valid` high with 0x11..0x16 changing on each accept.
  - First word pops at E1; `tx_ready` drops once `fifo_count`=4.
  - All six bytes appear in order, back-to-back, with no idle cycle between stop and start.
- Simultaneous push and pop: push on the exact cycle of the last stop-bit pop -> `fifo_count` unchanged and next frame starts immediately.
- STOP_BITS=2, DATA_W=7, BAUD_DIV=3: push 0x55 -> stop high 6 cycles; frame 30 cycles.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 words queued.
  - `rs232_tx`=1, `busy`=0 and `fifo_count`=0 asynchronously.
  - After release, push 0x3C -> clean frame starts at E1.
